demux8_buf: RTL

//   1-to-8 routing demultiplexer, the inverse of the 8:1 32-bit select mux.

---
 rtl/demux8_pkg.sv | 12 +
 rtl/demux8_buf_if.sv | 36 +++
 rtl/demux8_slot.sv | 73 +++++++
 rtl/demux8_buf.sv | 58 +++++
 4 files changed

// File: rtl/demux8_pkg.sv
// Shared constants and slot-state type for the 1-to-8 buffered demux.
package demux8_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux8_buf_if.sv
// Producer/consumer bundle of demux8_buf; out_cnt exists only when DEMUX8_CNT_EN is defined.
interface demux8_buf_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 8
);
  import demux8_pkg::*;

  logic                     in_vld;
  logic [SEL_W-1:0]         in_sel;
  logic [DATA_W-1:0]        in_data;
  logic                     in_rdy;
  logic [NUM_CH-1:0]        out_vld;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        out_rdy;
`ifdef DEMUX8_CNT_EN
  logic [NUM_CH*CNT_W-1:0]  out_cnt;
`endif

  // Drives the producer inputs and consumer ready lines.
  modport master (
    output in_vld, in_sel, in_data, out_rdy,
`ifdef DEMUX8_CNT_EN
    input  out_cnt,
`endif
    input  in_rdy, out_vld, out_data
  );

  modport slave (
    input  in_vld, in_sel, in_data, out_rdy,
`ifdef DEMUX8_CNT_EN
    output out_cnt,
`endif
    output in_rdy, out_vld, out_data
  );

endinterface

// File: rtl/demux8_slot.sv
// One demux channel: single-entry holding register with fill/drain FSM.
// Optional delivery counter enabled by DEMUX8_CNT_EN.
module demux8_slot
  import demux8_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              rdy_i,
`ifdef DEMUX8_CNT_EN
  output logic [CNT_W-1:0]  cnt_o,
`endif
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o
);

  slot_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              drain;

  assign drain = (state_q == SLOT_FULL) && rdy_i;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    // A fill on the same edge as a drain wins, keeping the slot full with new data.
    if (fill_i) begin
      state_d = SLOT_FULL;
      data_d  = data_i;
    end else if (drain) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign vld_o  = (state_q == SLOT_FULL);
  assign data_o = data_q;

`ifdef DEMUX8_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (drain) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/demux8_buf.sv
// 1-to-8 buffered routing demux: steers one write stream to 8 stallable channels.
// Per-channel delivery counters are built only when DEMUX8_CNT_EN is defined.
module demux8_buf
  import demux8_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  demux8_buf_if.slave  bus
);

  logic [NUM_CH-1:0]        vld;
  logic [NUM_CH*DATA_W-1:0] data;
  logic [NUM_CH-1:0]        fill_en;
  logic [SEL_W-1:0]         sel_eff;
  logic                     in_rdy;

  // Mask the select while idle so an undriven in_sel cannot leak X into in_rdy.
  assign sel_eff = bus.in_vld ? bus.in_sel : '0;
  assign in_rdy  = !vld[sel_eff] || bus.out_rdy[sel_eff];

  always_comb begin
    fill_en = '0;
    if (bus.in_vld && in_rdy) begin
      fill_en[sel_eff] = 1'b1;
    end
  end

`ifdef DEMUX8_CNT_EN
  logic [NUM_CH*CNT_W-1:0] cnt;
  assign bus.out_cnt = cnt;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux8_slot #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .fill_i (fill_en[k]),
      .data_i (bus.in_data),
      .rdy_i  (bus.out_rdy[k]),
`ifdef DEMUX8_CNT_EN
      .cnt_o  (cnt[k*CNT_W +: CNT_W]),
`endif
      .vld_o  (vld[k]),
      .data_o (data[k*DATA_W +: DATA_W])
    );
  end

  assign bus.in_rdy   = in_rdy;
  assign bus.out_vld  = vld;
  assign bus.out_data = data;

endmodule
